// File: rtl/apb_uart_rx_slave_pkg.sv
// Shared constants for the APB UART receiver: register offsets, STATUS bits, FSM states.
package apb_uart_rx_slave_pkg;

  // Register select, decoded from paddr[3:2]
  localparam logic [1:0] REG_RXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CLKDIV = 2'd2;

  // STATUS bit positions
  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME_ERR = 3;

  // Smallest usable divider: half-bit wait must be at least one cycle
  localparam logic [15:0] MIN_CLKDIV = 16'd2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < MIN_CLKDIV) ? MIN_CLKDIV : d;
  endfunction

endpackage

// File: rtl/apb_uart_rx_slave_fifo.sv
// Small synchronous FIFO for received bytes; push and pop may coincide.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [AW:0]                 count;
  logic                        do_push, do_pop;

  // A push into a full FIFO only lands if a pop frees the slot this cycle
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at power-of-2 depth
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/apb_uart_rx_slave.sv
// APB slave receiving 8N1 UART frames into a FIFO, with status, divider and IRQ.
module apb_uart_rx_slave
  import apb_uart_rx_slave_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter int          FIFO_DEPTH     = 4,
  parameter logic [15:0] DEFAULT_CLKDIV = 16'd16
) (
  input  logic                  pclk,
  input  logic                  Reset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic                  rx,
  output logic                  rx_irq
);
  logic        rx_m, rx_s;
  rx_state_e   state, state_nxt;
  logic [15:0] cnt, cnt_nxt, div, div_nxt, clkdiv;
  logic [2:0]  bit_cnt, bit_nxt;
  logic [7:0]  shift, shift_nxt, fifo_head;
  logic        push, ferr_set, ovr_set, pop;
  logic        overrun, frame_err, fifo_full, fifo_empty;
  logic        access, wr_acc, rd_acc;
  logic [1:0]  reg_sel;
  logic [3:0]  status;
  logic        unused_bits;

  assign unused_bits = ^{paddr[ADDR_WIDTH-1:4], paddr[1:0], pwdata[DATA_WIDTH-1:16]};

  assign access  = psel & penable;
  assign wr_acc  = access & pwrite;
  assign rd_acc  = access & ~pwrite;
  assign reg_sel = paddr[3:2];
  assign pready  = 1'b1;
  assign pslverr = access & (reg_sel == 2'd3);
  assign pop     = rd_acc & (reg_sel == REG_RXDATA);
  assign ovr_set = push & fifo_full & ~pop;

  assign status = {frame_err, overrun, fifo_full, ~fifo_empty};

  // Two-flop synchronizer; resets to idle-high so reset cannot fake a start bit
  always_ff @(posedge pclk) begin
    if (Reset) {rx_s, rx_m} <= 2'b11;
    else       {rx_s, rx_m} <= {rx_m, rx};
  end

  // Receiver state and datapath registers
  always_ff @(posedge pclk) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      div     <= DEFAULT_CLKDIV;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      div     <= div_nxt;
      bit_cnt <= bit_nxt;
      shift   <= shift_nxt;
    end
  end

  // Next-state: half-bit to centre on the start bit, then full bits thereafter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 16'd1;
    div_nxt   = div;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    push      = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) begin
          state_nxt = START;
          div_nxt   = clkdiv;  // divider frozen for the whole frame
        end
      end
      START: if (cnt == (div >> 1) - 16'd1) begin
        cnt_nxt   = '0;
        bit_nxt   = '0;
        state_nxt = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == div - 16'd1) begin
        cnt_nxt   = '0;
        shift_nxt = {rx_s, shift[7:1]};
        bit_nxt   = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_nxt = STOP;
      end
      STOP: if (cnt == div - 16'd1) begin
        cnt_nxt = '0;
        if (rx_s) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end else begin
          ferr_set  = 1'b1;
          state_nxt = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  uart_rx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (pclk),
    .reset (Reset),
    .push  (push),
    .pop   (pop),
    .din   (shift),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Register writes and sticky flags; a hardware set beats a same-cycle clear
  always_ff @(posedge pclk) begin
    if (Reset) begin
      clkdiv    <= DEFAULT_CLKDIV;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      rx_irq    <= 1'b0;
    end else begin
      if (wr_acc && reg_sel == REG_CLKDIV) clkdiv <= clamp_div(pwdata[15:0]);
      if (wr_acc && reg_sel == REG_STATUS && pwdata[ST_OVERRUN])   overrun   <= 1'b0;
      if (wr_acc && reg_sel == REG_STATUS && pwdata[ST_FRAME_ERR]) frame_err <= 1'b0;
      if (ovr_set)  overrun   <= 1'b1;
      if (ferr_set) frame_err <= 1'b1;
      rx_irq <= ~fifo_empty | overrun | frame_err;
    end
  end

  // Read mux, only driven during a read access phase
  always_comb begin
    prdata = '0;
    if (rd_acc) begin
      case (reg_sel)
        REG_RXDATA: prdata[7:0]  = fifo_empty ? 8'h00 : fifo_head;
        REG_STATUS: prdata[3:0]  = status;
        REG_CLKDIV: prdata[15:0] = clkdiv;
        default:    ;
      endcase
    end
  end
endmodule
